// File: rtl/branch_resolver_if.sv
// EX-stage branch resolution bus: EX inputs toward the resolver, plus the
// redirect and statistics outputs returned to the front end.
interface branch_resolver_if #(
    parameter int CNT_W = 16
);
    logic             PL_stall_ex;
    logic             branch_ex;
    logic             SP_prediction_result_ex;
    logic             branch_taken_ex;
    logic [31:0]      pc_ex;
    logic [31:0]      imme_ex;
    logic             clear_cnt;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             shadow_active;

    // EX pipeline side: drives branch info, consumes redirect and stats
    modport master (
        output PL_stall_ex, branch_ex, SP_prediction_result_ex, branch_taken_ex,
               pc_ex, imme_ex, clear_cnt,
        input  redirect_valid, redirect_pc, branch_cnt, miss_cnt, shadow_active
    );

    // Resolver side
    modport slave (
        input  PL_stall_ex, branch_ex, SP_prediction_result_ex, branch_taken_ex,
               pc_ex, imme_ex, clear_cnt,
        output redirect_valid, redirect_pc, branch_cnt, miss_cnt, shadow_active
    );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: compares the static prediction with the resolved outcome
// in EX, issues a one-cycle registered redirect on a mispredict, masks
// wrong-path branches for SHADOW_CYCLES advancing cycles afterwards, and
// keeps saturating branch/mispredict counters.
module branch_resolver #(
    parameter int SHADOW_CYCLES = 3,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolver_if.slave bus
);
    typedef enum logic {IDLE, SHADOW} state_t;

    state_t           state;
    logic [3:0]       shadow_cnt;
    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic             shadow_active_q;
    logic [CNT_W-1:0] branch_q;
    logic [CNT_W-1:0] miss_q;

    logic        evaluate;
    logic        mispredict;
    logic [31:0] target;

    // Qualify the EX branch and form the corrected fetch address
    always_comb begin
        evaluate   = bus.branch_ex & ~bus.PL_stall_ex & (state == IDLE);
        mispredict = evaluate & (bus.SP_prediction_result_ex != bus.branch_taken_ex);
        target     = bus.branch_taken_ex ? (bus.pc_ex + bus.imme_ex) : (bus.pc_ex + 32'd4);
    end

    // Redirect/shadow FSM; redirect_valid defaults low so it only ever pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            shadow_cnt       <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            shadow_active_q  <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state            <= SHADOW;
                        shadow_cnt       <= 4'(SHADOW_CYCLES);
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= target;
                        shadow_active_q  <= 1'b1;
                    end
                end
                SHADOW: begin
                    // Only advancing cycles drain the wrong-path window
                    if (!bus.PL_stall_ex) begin
                        if (shadow_cnt == 4'd1) begin
                            state           <= IDLE;
                            shadow_cnt      <= 4'd0;
                            shadow_active_q <= 1'b0;
                        end else begin
                            shadow_cnt <= shadow_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    shadow_cnt      <= 4'd0;
                    shadow_active_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics counters; clear wins over same-cycle increments
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_q <= '0;
            miss_q   <= '0;
        end else if (bus.clear_cnt) begin
            branch_q <= '0;
            miss_q   <= '0;
        end else begin
            if (evaluate && (branch_q != '1))
                branch_q <= branch_q + CNT_W'(1);
            if (mispredict && (miss_q != '1))
                miss_q <= miss_q + CNT_W'(1);
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.shadow_active  = shadow_active_q;
    assign bus.branch_cnt     = branch_q;
    assign bus.miss_cnt       = miss_q;
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage counterpart of the static branch predictor. Consumes the prediction bit piped down to EX together with the actual branch outcome, detects mispredictions, and issues a one-cycle registered redirect (corrected PC plus flush) to the fetch/decode front end. Masks wrong-path branches still draining through the pipeline after a redirect. Keeps saturating branch and misprediction counters for performance observation.

## Interface
- SHADOW_CYCLES, 3: number of advancing EX cycles after a redirect during which EX branches are wrong-path and ignored (1..15).
- CNT_W, 16: width of statistics counters.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- PL_stall_ex  in  1  EX stage stalled; EX inputs are held and not evaluated.
- branch_ex  in  1  valid conditional branch occupies EX this cycle.
- SP_prediction_result_ex  in  1  predicted direction for the EX branch (1 = taken).
- branch_taken_ex  in  1  resolved actual direction (1 = taken).
- pc_ex  in  32  PC of the EX instruction.
- imme_ex  in  32  sign-extended branch offset.
- clear_cnt  in  1  synchronous clear of both counters.
- redirect_valid  out  1  one-cycle pulse: front end must load redirect_pc and flush IF/ID.
- redirect_pc  out  32  corrected fetch address, valid while redirect_valid.
- branch_cnt  out  CNT_W  resolved branches counted.
- miss_cnt  out  CNT_W  mispredictions counted.
- shadow_active  out  1  high while in SHADOW state.

## Operation
- Evaluate = branch_ex & !PL_stall_ex & (state == IDLE).
- Mispredict = Evaluate & (SP_prediction_result_ex != branch_taken_ex).
- Target on mispredict: actual taken -> pc_ex + imme_ex; actual not-taken -> pc_ex + 32'd4. Both 32-bit, wrap modulo 2^32, no overflow flag.
- FSM, two states:
  - IDLE: on Mispredict -> SHADOW, load shadow counter with SHADOW_CYCLES. Otherwise stay.
  - SHADOW: counter decrements by 1 on each cycle with !PL_stall_ex; holds when stalled. Returns to IDLE on the advancing cycle where counter is 1. branch_ex ignored entirely (no redirect, no counting).
- Counters: branch_cnt += 1 on Evaluate; miss_cnt += 1 on Mispredict. Both saturate at all-ones. clear_cnt zeroes both and overrides same-cycle increments.
- Correct prediction: counted only; no redirect, state unchanged.

## Timing
- Reset values: redirect_valid 0, redirect_pc 32'h0, branch_cnt 0, miss_cnt 0, shadow_active 0, state IDLE, shadow counter 0.
- Latency: Mispredict in cycle N -> redirect_valid and redirect_pc registered, visible in cycle N+1 for exactly one cycle; shadow_active high from N+1.
- redirect_valid is a single-cycle pulse regardless of PL_stall_ex in N+1; redirect_pc holds its last value after the pulse.
- Counters update visibly in cycle N+1 after the qualifying cycle N.
- Stall in cycle N: no evaluation, no count, even if branch_ex high; branch re-evaluated when stall drops (same instruction counted once).
- Shadow exit: with no stalls, shadow_active high in N+1..N+SHADOW_CYCLES; first evaluable branch in cycle N+SHADOW_CYCLES+1.
- Reset asserted mid-SHADOW or coincident with a mispredict: immediate return to reset values; no pulse emitted.
- Back-to-back mispredicts impossible by construction (SHADOW masks); SHADOW_CYCLES >= 1 guaranteed.

## Test plan
- Reset then idle: rst pulse, no branches for 10 cycles -> all outputs 0, shadow_active 0.
- Correct predictions: 4 branches, prediction == outcome, no stalls -> branch_cnt 4, miss_cnt 0, redirect_valid never high.
- Predicted not-taken, taken: pc_ex 32'h0000_1000, imme_ex 32'hFFFF_FFF0 -> next cycle redirect_valid 1 for one cycle, redirect_pc 32'h0000_0FF0, miss_cnt 1; predicted taken, not-taken at pc_ex 32'hFFFF_FFFC -> redirect_pc 32'h0000_0000.
- Shadow masking with stall: mispredict, then branch_ex high every cycle, PL_stall_ex high for 2 cycles inside SHADOW -> shadow_active lasts 3+2 = 5 cycles, no counts during it, next branch counted.
- Stall hold: branch_ex high with PL_stall_ex high 3 cycles, then low -> branch_cnt increments exactly once.
- Saturation/clear: CNT_W=4, 20 mispredicts spaced past shadow -> miss_cnt 4'hF; clear_cnt coincident with a mispredict -> both counters 0, redirect still issued; async rst during SHADOW -> shadow_active 0 immediately.
